// File: rtl/commit_pkg.sv
// Shared types and dispatch-record layout for the reorder-buffer back end.
// Record layout, LSB first: isCsr, isSu, isBranch, rn[RB], rd[5], pc[64].
package commit_pkg;

    localparam int RB              = 2;
    localparam int RP              = 2 ** RB;
    localparam int REORDER_INFO_DW = 64 + 5 + RB + 3;

    localparam int ISCSR_BIT    = 0;
    localparam int ISSU_BIT     = 1;
    localparam int ISBRANCH_BIT = 2;
    localparam int RN_LSB       = 3;
    localparam int RD_LSB       = RN_LSB + RB;
    localparam int PC_LSB       = RD_LSB + 5;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } commit_state_e;

endpackage

// File: rtl/commit_if.sv
// Dispatch-to-commit reorder-FIFO handshake: record, push strobe and full back-pressure.
// Dispatch is the master; it must not push while full is high.
interface commit_if #(
    parameter int INFO_DW = commit_pkg::REORDER_INFO_DW
);
    logic [INFO_DW-1:0] dispat_info;
    logic               reOrder_fifo_push;
    logic               reOrder_fifo_full;

    modport master (
        output dispat_info,
        output reOrder_fifo_push,
        input  reOrder_fifo_full
    );

    modport slave (
        input  dispat_info,
        input  reOrder_fifo_push,
        output reOrder_fifo_full
    );
endinterface

// File: rtl/commit_gen_fifo.sv
// Generic DEPTH x DW circular buffer; pushed data is visible at dout_o one cycle later.
// Back-pressure: push is dropped while full (even when popping); flush_i empties it and wins over push/pop.
module gen_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra MSB is the wrap bit: equal indices mean full when the wrap bits differ.
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty_o = (wptr_q == rptr_q);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/commit.sv
// In-order retire of the reorder FIFO head: rename-map update, phys-reg free, store release, mispredict flush.
// Retire outputs are combinational from head/inputs; flush is a registered one-cycle pulse; full back-pressures dispatch.
module commit
    import commit_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RB      = commit_pkg::RB,
    parameter int INFO_DW = 64 + 5 + RB + 3
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    commit_if.slave               disp,
    input  logic [32*(2**RB)-1:0] wbLog_qout,
    input  logic                  bru_res_valid,
    input  logic                  bru_mispredict,
    output logic [RB*32-1:0]      archi_X_qout,
    output logic [32*(2**RB)-1:0] rnBufU_commit_rst,
    output logic                  commit_su,
    output logic                  commit_valid,
    output logic [63:0]           commit_pc,
    output logic                  flush
);
    localparam int RD_LO = RN_LSB + RB;
    localparam int PC_LO = RD_LO + 5;

    commit_state_e      state_q, state_d;
    logic [RB*32-1:0]   archi_q, archi_d;

    logic [INFO_DW-1:0] head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_flush;

    logic [63:0]        head_pc;
    logic [4:0]         head_rd;
    logic [RB-1:0]      head_rn;
    logic [RB-1:0]      head_old_rn;
    logic               head_br;
    logic               head_su;
    logic               head_csr_unused;
    logic               head_ready;
    logic               retire;
    logic               mispredict_retire;

    assign head_pc         = head[PC_LO +: 64];
    assign head_rd         = head[RD_LO +: 5];
    assign head_rn         = head[RN_LSB +: RB];
    assign head_br         = head[ISBRANCH_BIT];
    assign head_su         = head[ISSU_BIT];
    // CSR ops retire on writeback exactly like ALU ops, so the flag is not decoded here.
    assign head_csr_unused = head[ISCSR_BIT];
    assign head_old_rn     = archi_q[int'(head_rd) * RB +: RB];

    // Younger entries are squashed on the mispredict retire edge, so the FLUSH cycle already sees an empty FIFO.
    assign fifo_push  = disp.reOrder_fifo_push && (state_q == S_RUN);
    assign fifo_flush = mispredict_retire || (state_q == S_FLUSH);

    gen_fifo #(
        .DEPTH (DEPTH),
        .DW    (INFO_DW)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTn),
        .push_i  (fifo_push),
        .din_i   (disp.dispat_info),
        .pop_i   (retire),
        .flush_i (fifo_flush),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        head_ready = 1'b0;
        if (head_br) begin
            head_ready = bru_res_valid;
        end else if (head_su) begin
            head_ready = 1'b1;
        end else begin
            head_ready = (head_rd == 5'd0) || wbLog_qout[{head_rd, head_rn}];
        end
    end

    assign retire            = !fifo_empty && (state_q == S_RUN) && head_ready;
    assign mispredict_retire = retire && head_br && bru_mispredict;

    always_comb begin
        rnBufU_commit_rst = '0;
        archi_d           = archi_q;
        // The superseded copy is the one the architectural map points at before this retire.
        if (retire && (head_rd != 5'd0)) begin
            rnBufU_commit_rst[{head_rd, head_old_rn}] = 1'b1;
            archi_d[int'(head_rd) * RB +: RB]         = head_rn;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (mispredict_retire) state_d = S_FLUSH;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_RUN;
            archi_q <= '0;
        end else begin
            state_q <= state_d;
            archi_q <= archi_d;
        end
    end

    assign disp.reOrder_fifo_full = fifo_full;
    assign archi_X_qout           = archi_q;
    assign commit_valid           = retire;
    assign commit_pc              = head_pc;
    assign commit_su              = retire && head_su;
    assign flush                  = (state_q == S_FLUSH);

endmodule

// File: tb/tb_commit.sv
// Directed bench for commit: hand-computed retire, map, free, store, flush and reset expectations.
module tb_commit;
    import commit_pkg::*;

    localparam int DEPTH = 4;

    logic               clk;
    logic               rstn;
    logic [32*RP-1:0]   wblog;
    logic               bru_vld;
    logic               bru_mis;
    logic [RB*32-1:0]   archi;
    logic [32*RP-1:0]   free_rst;
    logic               c_su;
    logic               c_vld;
    logic [63:0]        c_pc;
    logic               c_flush;

    int n_chk  = 0;
    int n_pass = 0;

    commit_if #(.INFO_DW(REORDER_INFO_DW)) dif ();

    commit #(
        .DEPTH   (DEPTH),
        .RB      (RB),
        .INFO_DW (REORDER_INFO_DW)
    ) dut (
        .CLK               (clk),
        .RSTn              (rstn),
        .disp              (dif),
        .wbLog_qout        (wblog),
        .bru_res_valid     (bru_vld),
        .bru_mispredict    (bru_mis),
        .archi_X_qout      (archi),
        .rnBufU_commit_rst (free_rst),
        .commit_su         (c_su),
        .commit_valid      (c_vld),
        .commit_pc         (c_pc),
        .flush             (c_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rstn && dif.reOrder_fifo_push && dif.reOrder_fifo_full)
            $error("producer pushed while reorder FIFO full");
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [REORDER_INFO_DW-1:0] mk(input logic [63:0] pc, input logic [4:0] rd,
                                                      input logic [RB-1:0] rn, input logic br,
                                                      input logic su, input logic csr);
        return {pc, rd, rn, br, su, csr};
    endfunction

    function automatic logic [127:0] onehot(input int idx);
        logic [127:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [RB-1:0] map_of(input int rd);
        return archi[rd*RB +: RB];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [REORDER_INFO_DW-1:0] rec);
        dif.dispat_info       = rec;
        dif.reOrder_fifo_push = 1'b1;
        tick();
        dif.reOrder_fifo_push = 1'b0;
    endtask

    initial begin
        rstn                  = 1'b0;
        wblog                 = '0;
        bru_vld               = 1'b0;
        bru_mis               = 1'b0;
        dif.dispat_info       = '0;
        dif.reOrder_fifo_push = 1'b0;

        #12;
        chk("rst_full",  dif.reOrder_fifo_full, 0);
        chk("rst_flush", c_flush, 0);
        chk("rst_valid", c_vld, 0);
        chk("rst_su",    c_su, 0);
        chk("rst_free",  free_rst, 0);
        chk("rst_map",   archi, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // ALU rd=5 rn=1 waits for writeback of {5,1}, frees {5,0}, maps 5->1
        push(mk(64'h100, 5, 1, 0, 0, 0));
        #1 chk("alu_wait", c_vld, 0);
        wblog[21] = 1'b1;
        #1;
        chk("alu_valid", c_vld, 1);
        chk("alu_pc",    c_pc, 64'h100);
        chk("alu_free",  free_rst, onehot(20));
        tick();
        chk("alu_map5",  map_of(5), 1);
        chk("alu_empty", c_vld, 0);
        wblog = '0;

        // Fill to full, retire one, refill across the wrap
        for (int i = 0; i < DEPTH; i++)
            push(mk(64'h200 + 64'(i), 5'(1 + i), 1, 0, 0, 0));
        #1;
        chk("fill_full",  dif.reOrder_fifo_full, 1);
        chk("fill_noret", c_vld, 0);
        wblog[5] = 1'b1;
        #1;
        chk("head0_pc",   c_pc, 64'h200);
        chk("head0_free", free_rst, onehot(4));
        tick();
        chk("after_pop_full", dif.reOrder_fifo_full, 0);
        push(mk(64'h204, 5, 2, 0, 0, 0));
        #1 chk("wrap_full", dif.reOrder_fifo_full, 1);

        wblog[9] = 1'b1; wblog[13] = 1'b1; wblog[17] = 1'b1; wblog[22] = 1'b1;
        #1;
        chk("r201_valid", c_vld, 1);
        chk("r201_pc",    c_pc, 64'h201);
        chk("r201_free",  free_rst, onehot(8));
        tick();
        dif.dispat_info       = mk(64'h205, 0, 0, 0, 0, 0);
        dif.reOrder_fifo_push = 1'b1;
        #1;
        chk("r202_pc",   c_pc, 64'h202);
        chk("r202_free", free_rst, onehot(12));
        tick();
        dif.reOrder_fifo_push = 1'b0;
        #1;
        chk("pushpop_notfull", dif.reOrder_fifo_full, 0);
        chk("r203_pc",   c_pc, 64'h203);
        chk("r203_free", free_rst, onehot(16));
        tick();
        #1;
        chk("r204_pc",   c_pc, 64'h204);
        chk("r204_free", free_rst, onehot(21));
        tick();
        #1;
        chk("rd0_valid",   c_vld, 1);
        chk("rd0_pc",      c_pc, 64'h205);
        chk("rd0_no_free", free_rst, 0);
        tick();
        #1 chk("drained", c_vld, 0);
        wblog = '0;
        chk("map_after_fill", archi, 64'h954);

        // Store retires at once, no map change
        push(mk(64'h300, 0, 0, 0, 1, 0));
        #1;
        chk("st_su",    c_su, 1);
        chk("st_valid", c_vld, 1);
        chk("st_free",  free_rst, 0);
        tick();
        chk("st_su_off", c_su, 0);
        chk("st_map",    archi, 64'h954);

        // Mispredicted branch with three younger entries
        push(mk(64'h400, 0, 0, 1, 0, 0));
        #1 chk("br_wait", c_vld, 0);
        for (int i = 0; i < 3; i++)
            push(mk(64'h401 + 64'(i), 6, 1, 0, 0, 0));
        bru_vld = 1'b1;
        bru_mis = 1'b1;
        #1;
        chk("br_valid",    c_vld, 1);
        chk("br_pc",       c_pc, 64'h400);
        chk("br_no_flush", c_flush, 0);
        tick();
        bru_vld               = 1'b0;
        bru_mis               = 1'b0;
        dif.dispat_info       = mk(64'h500, 0, 0, 0, 0, 0);
        dif.reOrder_fifo_push = 1'b1;
        #1;
        chk("flush_pulse",  c_flush, 1);
        chk("flush_noret",  c_vld, 0);
        chk("flush_nofull", dif.reOrder_fifo_full, 0);
        tick();
        dif.reOrder_fifo_push = 1'b0;
        #1;
        chk("flush_once",    c_flush, 0);
        chk("flush_dropped", c_vld, 0);
        push(mk(64'h600, 0, 0, 0, 0, 0));
        #1 chk("post_flush_pc", c_pc, 64'h600);
        chk("post_flush_vld", c_vld, 1);

        // Correctly predicted branch: retire, no flush
        push(mk(64'h700, 0, 0, 1, 0, 0));
        bru_vld = 1'b1;
        #1 chk("br_ok_valid", c_vld, 1);
        tick();
        bru_vld = 1'b0;
        chk("br_ok_noflush", c_flush, 0);

        // Asynchronous reset with two entries queued
        push(mk(64'h800, 7, 3, 0, 0, 0));
        push(mk(64'h801, 7, 2, 0, 0, 0));
        #1 chk("pre_rst_wait", c_vld, 0);
        #2;
        rstn      = 1'b0;
        wblog[31] = 1'b1;
        #1;
        chk("arst_valid", c_vld, 0);
        chk("arst_map",   archi, 0);
        chk("arst_full",  dif.reOrder_fifo_full, 0);
        chk("arst_flush", c_flush, 0);
        tick();
        rstn = 1'b1;
        #1 chk("arst_discard", c_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
